// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch/decode-front stage of the 16-bit single-cycle RISC core.
// Holds the PC, fetches one instruction word per request over a req/ack handshake,
// latches it in the instruction register and presents the split fields to decode.
// A redirect arriving while a request is outstanding parks the FSM in DRAIN so the
// stale response is swallowed rather than issued.
//
// Optional feature: define FETCH_CNT_EN to add fetch_count_o, a 16-bit wrapping
// count of accepted instructions. Without the macro the port and counter are absent.
module instruction_fetch #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       IMM_W    = 6,       // legal range 1..6
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              run_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [15:0]       imem_rdata_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [15:0]       instr_o,
   output logic [3:0]        opcode_o,
   output logic [2:0]        rd_o,
   output logic [2:0]        rs_o,
   output logic [2:0]        rt_o,
   output logic [IMM_W-1:0]  imm_o
`ifdef FETCH_CNT_EN
   ,
   output logic [15:0]       fetch_count_o
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_addr;
   logic [15:0]       ir;
   logic              valid;
   logic              req;
   logic [ADDR_W-1:0] pc_next;

   // Sequential PC advance; wraps modulo 2^ADDR_W with no special handling.
   assign pc_next = pc + ADDR_W'(PC_STEP);

   // Fetch FSM: redirect is checked first in every state; all outputs are registered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: every register here, the IR included, is reset so the fields read 0
         // out of reset; sequential state always uses <= so all flops sample together.
         state    <= S_IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         ir       <= 16'h0000;
         valid    <= 1'b0;
         req      <= 1'b0;
      end else if (redirect_i) begin
         pc    <= redirect_pc_i;
         valid <= 1'b0;
         case (state)
            S_HOLD: begin
               // Any same-cycle accept is discarded: the held word was on the wrong path.
               if (run_i) begin
                  state    <= S_REQ;
                  req_addr <= redirect_pc_i;
                  req      <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_REQ: begin
               // Response arriving now is stale; reissue at the target right away.
               // Otherwise keep req up and swallow the late response in DRAIN.
               if (imem_ack_i) req_addr <= redirect_pc_i;
               else            state    <= S_DRAIN;
            end
            default: ;  // IDLE and DRAIN only take the new pc
         endcase
      end else begin
         case (state)
            S_IDLE: begin
               if (run_i) begin
                  state    <= S_REQ;
                  req_addr <= pc;
                  req      <= 1'b1;
               end
            end
            S_REQ: begin
               if (imem_ack_i) begin
                  state <= S_HOLD;
                  ir    <= imem_rdata_i;
                  valid <= 1'b1;
                  req   <= 1'b0;
               end
            end
            S_HOLD: begin
               if (instr_ready_i) begin
                  pc    <= pc_next;
                  valid <= 1'b0;
                  if (run_i) begin
                     state    <= S_REQ;
                     req_addr <= pc_next;
                     req      <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DRAIN: begin
               // Drop the stale word and fetch from the redirected pc.
               if (imem_ack_i) begin
                  state    <= S_REQ;
                  req_addr <= pc;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef FETCH_CNT_EN
   logic [15:0] fetch_count;

   // Accepted-instruction counter; a redirect in the accept cycle cancels the count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                       fetch_count <= 16'h0000;
      else if (valid && instr_ready_i && !redirect_i) fetch_count <= fetch_count + 16'd1;
   end

   assign fetch_count_o = fetch_count;
`endif

   assign imem_req_o    = req;
   assign imem_addr_o   = req_addr;
   assign instr_valid_o = valid;
   assign pc_o          = pc;
   assign instr_o       = ir;

   // Decoded fields read as 0 whenever the IR does not hold a valid word.
   assign opcode_o = valid ? ir[15:12]      : 4'h0;
   assign rd_o     = valid ? ir[11:9]       : 3'h0;
   assign rs_o     = valid ? ir[8:6]        : 3'h0;
   assign rt_o     = valid ? ir[5:3]        : 3'h0;
   assign imm_o    = valid ? ir[IMM_W-1:0]  : '0;

endmodule
